// File: rtl/bp_pkg.sv
// Shared types and default sizing for the local-history branch predictor.
// The PHT counter encoding puts the predicted direction in bit 1.
package bp_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } cnt2_t;

   localparam cnt2_t PHT_INIT     = WNT;
   localparam int    BHT_BITS_DEF = 10;
   localparam int    HIST_LEN_DEF = 6;
   localparam int    PHT_BITS_DEF = 10;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of one 2-bit saturating pattern counter.
// Taken moves toward ST and not-taken moves toward SNT, holding at either end.
module sat_counter2
   import bp_pkg::*;
(
   input  cnt2_t i_cur,
   input  logic  i_taken,
   output cnt2_t o_next
);

   // Saturating increment on taken, saturating decrement on not-taken
   always_comb begin
      o_next = i_cur;
      case (i_cur)
         SNT: begin
            if (i_taken) o_next = WNT;
            else         o_next = SNT;
         end
         WNT: begin
            if (i_taken) o_next = WT;
            else         o_next = SNT;
         end
         WT: begin
            if (i_taken) o_next = ST;
            else         o_next = WNT;
         end
         ST: begin
            if (i_taken) o_next = ST;
            else         o_next = WT;
         end
         default: o_next = PHT_INIT;
      endcase
   end

endmodule

// File: rtl/bht_predictor.sv
// Two-level local-history branch predictor: per-pc history indexes a PHT of
// 2-bit counters (XOR-folded with the pc); trained and checked in the M stage.
module bht_predictor
   import bp_pkg::*;
#(
   parameter int BHT_BITS = BHT_BITS_DEF,
   parameter int HIST_LEN = HIST_LEN_DEF,
   parameter int PHT_BITS = PHT_BITS_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic        pcsrcM,
   input  logic        pcsrcPM,
   input  logic [31:0] fpcM,
   input  logic [31:0] pcM,
   input  logic        branchM,
   input  logic [31:0] pcD,
   input  logic        branchD,
   output logic        pbranchF,
   output logic        pmis,
   output logic        flushD,
   output logic        flushE,
   output logic        flushM,
   output logic [31:0] br_cnt,
   output logic [31:0] mis_cnt
);

   localparam int BHT_DEPTH = 1 << BHT_BITS;
   localparam int PHT_DEPTH = 1 << PHT_BITS;

   logic [HIST_LEN-1:0] r_bht [BHT_DEPTH];
   cnt2_t               r_pht [PHT_DEPTH];
   logic [31:0]         r_br_cnt;
   logic [31:0]         r_mis_cnt;

   logic [BHT_BITS-1:0] w_f_bidx;
   logic [HIST_LEN-1:0] w_f_hist;
   logic [PHT_BITS-1:0] w_f_pidx;
   logic [1:0]          w_f_cnt;

   logic [BHT_BITS-1:0] w_m_bidx;
   logic [HIST_LEN-1:0] w_m_hist;
   logic [HIST_LEN-1:0] w_m_hist_next;
   logic [PHT_BITS-1:0] w_m_pidx;
   cnt2_t               w_m_cur;
   cnt2_t               w_m_next;
   logic                w_mis;
   logic                w_unused;

   // Fetch-side lookup; reads see table contents from before this cycle's update
   assign w_f_bidx = pc[BHT_BITS+1:2];
   assign w_f_hist = r_bht[w_f_bidx];
   assign w_f_pidx = pc[PHT_BITS+1:2] ^ PHT_BITS'(w_f_hist);
   assign w_f_cnt  = r_pht[w_f_pidx];

   assign w_m_bidx = pcM[BHT_BITS+1:2];
   assign w_m_hist = r_bht[w_m_bidx];
   assign w_m_pidx = pcM[PHT_BITS+1:2] ^ PHT_BITS'(w_m_hist);
   assign w_m_cur  = r_pht[w_m_pidx];

   generate
      if (HIST_LEN > 1) begin : g_hist_shift
         assign w_m_hist_next = {w_m_hist[HIST_LEN-2:0], pcsrcM};
      end else begin : g_hist_single
         assign w_m_hist_next = pcsrcM;
      end
   endgenerate

   sat_counter2 u_sat (
      .i_cur   (w_m_cur),
      .i_taken (pcsrcM),
      .o_next  (w_m_next)
   );

   assign w_mis = branchM & (pcsrcM ^ pcsrcPM);

   // Outputs are forced low while reset is held
   assign pbranchF = rst & w_f_cnt[1];
   assign pmis     = rst & w_mis;
   assign flushD   = pmis;
   assign flushE   = pmis;
   assign flushM   = pmis;
   assign br_cnt   = r_br_cnt;
   assign mis_cnt  = r_mis_cnt;

   // Only the pc index fields are meaningful; the rest is interface compatibility
   assign w_unused = ^{pc, pcM, pcD, fpcM, branchD};

   // Branch history table: shift in the resolved outcome
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BHT_DEPTH; i++) begin
            r_bht[i] <= '0;
         end
      end else if (branchM) begin
         r_bht[w_m_bidx] <= w_m_hist_next;
      end
   end

   // Pattern history table: saturating counter update at the pre-update index
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < PHT_DEPTH; i++) begin
            r_pht[i] <= PHT_INIT;
         end
      end else if (branchM) begin
         r_pht[w_m_pidx] <= w_m_next;
      end
   end

   // Resolved-branch and mispredict statistics, wrapping naturally
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_br_cnt  <= 32'd0;
         r_mis_cnt <= 32'd0;
      end else if (branchM) begin
         r_br_cnt <= r_br_cnt + 32'd1;
         if (w_mis) begin
            r_mis_cnt <= r_mis_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_bht_predictor.sv
// Directed bench for bht_predictor: reset, training, saturation, no-train,
// read/write collision and asynchronous mid-run reset.
module tb_bht_predictor;
   import bp_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc, fpcM, pcM, pcD;
   logic        pcsrcM, pcsrcPM, branchM, branchD;
   logic        pbranchF, pmis, flushD, flushE, flushM;
   logic [31:0] br_cnt, mis_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bht_predictor dut (
      .clk      (clk),
      .rst      (rst),
      .pc       (pc),
      .pcsrcM   (pcsrcM),
      .pcsrcPM  (pcsrcPM),
      .fpcM     (fpcM),
      .pcM      (pcM),
      .branchM  (branchM),
      .pcD      (pcD),
      .branchD  (branchD),
      .pbranchF (pbranchF),
      .pmis     (pmis),
      .flushD   (flushD),
      .flushE   (flushE),
      .flushM   (flushM),
      .br_cnt   (br_cnt),
      .mis_cnt  (mis_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag, input logic [31:0] eb, input logic [31:0] em);
      chk({tag, ".br_cnt"}, br_cnt, eb);
      chk({tag, ".mis_cnt"}, mis_cnt, em);
   endtask

   // One M-stage cycle: drive, check combinational outputs, clock it in.
   task automatic step(input string tag, input logic [31:0] fpc, input logic [31:0] mpc,
                       input logic br, input logic tk, input logic pp,
                       input logic exp_pb, input logic exp_mis);
      pc      = fpc;
      pcD     = fpc;
      pcM     = mpc;
      fpcM    = mpc + 32'd4;
      branchM = br;
      pcsrcM  = tk;
      pcsrcPM = pp;
      #1;
      chk({tag, ".pbranchF"}, pbranchF, exp_pb);
      chk({tag, ".pmis_flush"}, {pmis, flushD, flushE, flushM}, {4{exp_mis}});
      @(posedge clk);
      #1;
      branchM = 1'b0;
   endtask

   initial begin
      rst = 1'b0; pc = 32'h0040_0010; pcD = 32'd0; branchD = 1'b0;
      fpcM = 32'd0; pcM = 32'h0040_0010;
      branchM = 1'b1; pcsrcM = 1'b1; pcsrcPM = 1'b0;

      // Held in reset: outputs low even with a mismatching M-stage branch
      #2;
      chk("rst.outs", {pbranchF, pmis, flushD, flushE, flushM}, 32'd0);
      chk_cnt("rst", 32'd0, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk_cnt("rst_clk", 32'd0, 32'd0);
      branchM = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // 1: idle after release
      step("t1", 32'h0040_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_cnt("t1", 32'd0, 32'd0);

      // 2: first taken branch at index 4, predicted not-taken
      step("t2", 32'h0040_0010, 32'h0040_0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("t2.pht4", dut.r_pht[4], WT);
      chk("t2.bht4", dut.r_bht[4], 32'd1);
      chk_cnt("t2", 32'd1, 32'd1);

      // 3: six more taken; histories 1,3,7,15,31,63 hit fresh WNT counters
      for (int k = 0; k < 6; k++) begin
         step("t3", 32'h0040_0010, 32'h0040_0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      end
      chk("t3.bht4", dut.r_bht[4], 32'h3f);
      chk("t3.pht59", dut.r_pht[59], WT);
      chk_cnt("t3", 32'd7, 32'd7);
      step("t3_8", 32'h0040_0010, 32'h0040_0010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("t3_8.pht59", dut.r_pht[59], ST);
      chk_cnt("t3_8", 32'd8, 32'd7);
      step("t3_9", 32'h0040_0010, 32'h0040_0010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("t3_9.pht59", dut.r_pht[59], ST);
      chk_cnt("t3_9", 32'd9, 32'd7);

      // 4: branchM low with a direction mismatch trains nothing
      step("t4", 32'h0040_0010, 32'h0040_0010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("t4.bht4", dut.r_bht[4], 32'h3f);
      chk("t4.pht59", dut.r_pht[59], ST);
      chk_cnt("t4", 32'd9, 32'd7);

      // 5a: saturate history of index 256 to all-ones (counters 256..287 -> WT)
      for (int k = 0; k < 6; k++) begin
         step("t5_fill", 32'h0040_0400, 32'h0040_0400, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      end
      chk("t5.bht256", dut.r_bht[256], 32'h3f);
      chk_cnt("t5_fill", 32'd15, 32'd13);
      // 5b: fetch and train the same entry; index 319 stays stable across the update
      step("t5_col", 32'h0040_0400, 32'h0040_0400, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      step("t5_next", 32'h0040_0400, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk_cnt("t5_col", 32'd16, 32'd14);
      // 5c: not-taken at index 512 with zero history: WNT -> SNT -> SNT
      step("t5_snt1", 32'h0040_0800, 32'h0040_0800, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("t5_snt1.pht512", dut.r_pht[512], SNT);
      step("t5_snt2", 32'h0040_0800, 32'h0040_0800, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t5_snt2.pht512", dut.r_pht[512], SNT);
      step("t5_snt3", 32'h0040_0800, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_cnt("t5_snt", 32'd18, 32'd15);

      // 6: asynchronous reset between edges while a mispredict is pending
      pc = 32'h0040_0010; pcM = 32'h0040_0010;
      branchM = 1'b1; pcsrcM = 1'b0; pcsrcPM = 1'b1;
      #1;
      chk("t6_pre.pbranchF", pbranchF, 32'd1);
      chk("t6_pre.pmis", pmis, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("t6.outs", {pbranchF, pmis, flushD, flushE, flushM}, 32'd0);
      chk_cnt("t6", 32'd0, 32'd0);
      repeat (2) @(posedge clk);
      branchM = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      step("t6_a", 32'h0040_0010, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("t6_b", 32'h0040_0400, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("t6_c", 32'h0040_0020, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t6.bht4", dut.r_bht[4], 32'd0);
      chk("t6.pht59", dut.r_pht[59], WNT);
      chk_cnt("t6_post", 32'd0, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bht_predictor.md
Name: bht_predictor

Overview:
Two-level local-history branch predictor for the 5-stage MIPS pipeline.
- Fetch: gives a taken/not-taken prediction for the current fetch pc.
- Memory stage: checks each resolved branch against its prediction and raises the mispredict redirect and pipeline flushes.
- Memory stage: trains its tables on the actual outcome.
- The datapath consumes pbranchF, pmis and flushD/E/M. The port order below is the instantiation order.

Parameters:
BHT_BITS, 10, log2 number of branch-history entries; index = pc[BHT_BITS+1:2]
HIST_LEN, 6, bits of local history per BHT entry; must be <= PHT_BITS
PHT_BITS, 10, log2 number of 2-bit pattern counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-low
pc  in  32  current fetch pc
pcsrcM  in  1  actual branch direction, M stage
pcsrcPM  in  1  predicted direction carried to M stage
fpcM  in  32  recovery pc; mux select belongs to the datapath, not used internally
pcM  in  32  pc of the instruction in M stage
branchM  in  1  M-stage instruction is a branch
pcD  in  32  D-stage pc; interface compatibility only, unused
branchD  in  1  D-stage branch flag; unused
pbranchF  out  1  prediction for pc
pmis  out  1  mispredict in M stage
flushD  out  1  clear F->D register
flushE  out  1  clear D->E register
flushM  out  1  clear E->M register
br_cnt  out  32  resolved-branch counter
mis_cnt  out  32  mispredict counter

Behaviour:
Reset (rst=0, asynchronous):
- Every BHT entry is cleared to 0.
- Every PHT counter is set to WNT (2'b01).
- br_cnt and mis_cnt are set to 0.
- While in reset, all outputs are 0, including pbranchF.

Prediction (combinational, same cycle):
- h = BHT[pc[BHT_BITS+1:2]].
- i = pc[PHT_BITS+1:2] XOR zero-extended h.
- pbranchF = PHT[i][1].

Mispredict (combinational, same cycle):
- pmis = branchM & (pcsrcM != pcsrcPM).
- flushD = flushE = flushM = pmis.
- When pmis and a datapath stall coincide, the flush wins; that is the datapath's concern, and pmis is unchanged.

Training (registered, on the edge while branchM=1):
- hu = BHT[pcM[BHT_BITS+1:2]], the value before the update.
- iu = pcM[PHT_BITS+1:2] XOR hu.
- PHT[iu] moves as a saturating 2-bit counter: +1 on pcsrcM=1, -1 on pcsrcM=0. It saturates at SNT(00) and ST(11).
- BHT entry <= {hu[HIST_LEN-2:0], pcsrcM}, i.e. newest outcome in the LSB.
- br_cnt increments by 1; mis_cnt increments when pmis=1. Both wrap modulo 2^32.

When branchM=0:
- No table or counter changes, even if pcsrcM differs from pcsrcPM.

Read/write collision:
- The fetch read of an entry being written in the same cycle returns the old value; there is no bypass.
- The new value is visible from the next cycle.

Latency:
- Prediction has 0 cycles of latency.
- A training update is visible to fetch 1 cycle after the M-stage cycle.

Tables are flop arrays (async reset required); no SRAM.

Decomposition:
- Package bp_pkg holds:
  - the typedef cnt2_t, an enum {SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11};
  - the reset constant PHT_INIT=WNT;
  - the default index widths.
- Sub-module sat_counter2 is the pure next-state function of one PHT counter (cur, taken -> next) and is instantiated once in the update path.
- The tables stay in bht_predictor.

Test Plan:
1. Release rst, pc=0x00400000, branchM=0 -> pbranchF=0, pmis=0, flushD/E/M=0, br_cnt=mis_cnt=0.
2. branchM=1, pcM=0x00400010, pcsrcM=1, pcsrcPM=0 -> same cycle pmis=flushD=flushE=flushM=1; next cycle PHT[4]=WT, BHT[4]=6'b000001, br_cnt=1, mis_cnt=1.
3. Resolve the branch at pcM=0x00400010 taken 7 consecutive times, with pcsrcPM matching the current prediction each time -> BHT[4]=6'b111111 and PHT[4^63]=WT; pbranchF=1 for pc=0x00400010. An 8th taken resolution -> counter ST; a 9th leaves it at ST.
4. branchM=0, pcsrcM=1, pcsrcPM=0 -> pmis=0, no flushes, tables and counters unchanged.
5. Same cycle: pc=pcM=0x00400020, branchM=1, taken, counter at WNT -> pbranchF=0 that cycle, 1 the next (if the BHT update keeps the index stable, force HIST via a 0-history scenario with HIST_LEN reduced in a variant build); also drive a counter to SNT and train not-taken -> stays SNT.
6. Assert rst=0 mid-training, asynchronously and between edges -> outputs drop immediately; after release, pbranchF=0 for every trained pc and br_cnt=mis_cnt=0.
